decode_stage: RTL

//  ID stage of the 5-stage MIPS pipeline; consumes fetch outputs (instructionf, pc_plus_4f).

---
 rtl/decode_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// ID stage of a 5-stage MIPS pipeline: IF/ID register, 32x32 register file, control decode and early branch resolution.
// Optional feature: define REGFILE_BYPASS_EN to forward the same-cycle WB write onto the register reads.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instructionf,
  input  logic [31:0] pc_plus_4f,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        regwrite_w,
  input  logic [4:0]  write_reg_w,
  input  logic [31:0] result_w,
  input  logic        forward_ad,
  input  logic        forward_bd,
  input  logic [31:0] alu_out_m,
  output logic [31:0] pc_branch_d,
  output logic        pcsrc_d,
  output logic [31:0] rd1_d,
  output logic [31:0] rd2_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  rd_d,
  output logic [31:0] sign_imm_d,
  output logic        regwrite_d,
  output logic        memtoreg_d,
  output logic        memwrite_d,
  output logic        alusrc_d,
  output logic        regdst_d,
  output logic [2:0]  alucontrol_d
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus_4_q, pc_plus_4_d;
  logic [31:0] regs_q [32];
  logic        reg_we_s;
  logic [31:0] rd1_s, rd2_s;
  logic        beq_s, bne_s;
  logic [31:0] cmp_a_s, cmp_b_s;

  // IF/ID next-state: stall wins over flush, flush loads a nop
  always_comb begin
    instr_d     = instr_q;
    pc_plus_4_d = pc_plus_4_q;
    if (stalld) begin
      instr_d     = instr_q;
      pc_plus_4_d = pc_plus_4_q;
    end else if (flushd) begin
      instr_d     = 32'd0;
      pc_plus_4_d = 32'd0;
    end else begin
      instr_d     = instructionf;
      pc_plus_4_d = pc_plus_4f;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= 32'd0;
      pc_plus_4_q <= 32'd0;
    end else begin
      instr_q     <= instr_d;
      pc_plus_4_q <= pc_plus_4_d;
    end
  end

  assign reg_we_s = regwrite_w && (write_reg_w != 5'd0);

  // Register file storage; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (reg_we_s) begin
      regs_q[write_reg_w] <= result_w;
    end
  end

  assign rs_d       = instr_q[25:21];
  assign rt_d       = instr_q[20:16];
  assign rd_d       = instr_q[15:11];
  assign sign_imm_d = {{16{instr_q[15]}}, instr_q[15:0]};

  // Combinational register reads, optionally bypassing the WB write
  always_comb begin
    rd1_s = regs_q[rs_d];
    rd2_s = regs_q[rt_d];
`ifdef REGFILE_BYPASS_EN
    if (reg_we_s && (write_reg_w == rs_d)) begin
      rd1_s = result_w;
    end else begin
      rd1_s = regs_q[rs_d];
    end
    if (reg_we_s && (write_reg_w == rt_d)) begin
      rd2_s = result_w;
    end else begin
      rd2_s = regs_q[rt_d];
    end
`else
    if (rs_d == 5'd0) begin
      rd1_s = 32'd0;
    end else begin
      rd1_s = regs_q[rs_d];
    end
    if (rt_d == 5'd0) begin
      rd2_s = 32'd0;
    end else begin
      rd2_s = regs_q[rt_d];
    end
`endif
  end

  assign rd1_d = rd1_s;
  assign rd2_d = rd2_s;

  // Main control decode; unsupported encodings leave every control at 0
  always_comb begin
    regwrite_d   = 1'b0;
    memtoreg_d   = 1'b0;
    memwrite_d   = 1'b0;
    alusrc_d     = 1'b0;
    regdst_d     = 1'b0;
    alucontrol_d = 3'b000;
    beq_s        = 1'b0;
    bne_s        = 1'b0;
    case (instr_q[31:26])
      OP_RTYPE: begin
        case (instr_q[5:0])
          FN_ADD: begin regwrite_d = 1'b1; regdst_d = 1'b1; alucontrol_d = 3'b010; end
          FN_SUB: begin regwrite_d = 1'b1; regdst_d = 1'b1; alucontrol_d = 3'b110; end
          FN_AND: begin regwrite_d = 1'b1; regdst_d = 1'b1; alucontrol_d = 3'b000; end
          FN_OR:  begin regwrite_d = 1'b1; regdst_d = 1'b1; alucontrol_d = 3'b001; end
          FN_SLT: begin regwrite_d = 1'b1; regdst_d = 1'b1; alucontrol_d = 3'b111; end
          default: begin
            regwrite_d   = 1'b0;
            regdst_d     = 1'b0;
            alucontrol_d = 3'b000;
          end
        endcase
      end
      OP_LW: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        memtoreg_d   = 1'b1;
        alucontrol_d = 3'b010;
      end
      OP_SW: begin
        memwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        alucontrol_d = 3'b010;
      end
      OP_ADDI: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        alucontrol_d = 3'b010;
      end
      OP_BEQ: begin
        beq_s        = 1'b1;
        alucontrol_d = 3'b110;
      end
      OP_BNE: begin
        bne_s        = 1'b1;
        alucontrol_d = 3'b110;
      end
      default: begin
        regwrite_d   = 1'b0;
        alucontrol_d = 3'b000;
      end
    endcase
  end

  // Early branch resolution with MEM-stage forwarding of either operand
  always_comb begin
    cmp_a_s = rd1_s;
    cmp_b_s = rd2_s;
    pcsrc_d = 1'b0;
    if (forward_ad) begin
      cmp_a_s = alu_out_m;
    end else begin
      cmp_a_s = rd1_s;
    end
    if (forward_bd) begin
      cmp_b_s = alu_out_m;
    end else begin
      cmp_b_s = rd2_s;
    end
    if (beq_s) begin
      pcsrc_d = (cmp_a_s == cmp_b_s);
    end else if (bne_s) begin
      pcsrc_d = (cmp_a_s != cmp_b_s);
    end else begin
      pcsrc_d = 1'b0;
    end
  end

  assign pc_branch_d = pc_plus_4_q + {sign_imm_d[29:0], 2'b00};

endmodule
